// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin two-client arbiter and pipelined sequencer for a single-port SRAM macro.
module sram_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              csb_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] dout
);
  logic              last_q, last_d, grant, accept, acc_we;
  logic              csb_n_q, csb_n_d, we_n_q, we_n_d;
  logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [RD_LAT:0]   tv_q, tv_d, to_q, to_d, tr_q, tr_d;
  // Tag pipeline: tv = in flight, to = owner, tr = is_read; stage RD_LAT lines up with valid dout.
  always_comb begin
    grant = (req0_valid & req1_valid) ? ~last_q : ~req0_valid;
    req0_ready = req0_valid & ~grant & ~reset;
    req1_ready = req1_valid & grant & ~reset;
    accept = req0_ready | req1_ready;
    acc_we = grant ? req1_we : req0_we;
    last_d = accept ? grant : last_q;
    csb_n_d = ~accept;
    we_n_d = ~(accept & acc_we);
    addr_d = accept ? (grant ? req1_addr : req0_addr) : addr_q;
    din_d = accept ? (grant ? req1_wdata : req0_wdata) : din_q;
    tv_d[0] = accept;
    to_d[0] = grant;
    tr_d[0] = ~acc_we;
    for (int i = 1; i <= RD_LAT; i++) begin
      tv_d[i] = tv_q[i-1];
      to_d[i] = to_q[i-1];
      tr_d[i] = tr_q[i-1];
    end
    rsp0_valid_d = tv_q[RD_LAT] & ~to_q[RD_LAT];
    rsp1_valid_d = tv_q[RD_LAT] & to_q[RD_LAT];
    rdata0_d = (rsp0_valid_d & tr_q[RD_LAT]) ? dout : rdata0_q;
    rdata1_d = (rsp1_valid_d & tr_q[RD_LAT]) ? dout : rdata1_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
      csb_n_q <= 1'b1;
      we_n_q <= 1'b1;
      addr_q <= '0;
      din_q <= '0;
      tv_q <= '0;
      to_q <= '0;
      tr_q <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      last_q <= last_d;
      csb_n_q <= csb_n_d;
      we_n_q <= we_n_d;
      addr_q <= addr_d;
      din_q <= din_d;
      tv_q <= tv_d;
      to_q <= to_d;
      tr_q <= tr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign csb_n = csb_n_q;
  assign we_n = we_n_q;
  assign addr = addr_q;
  assign din = din_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rdata0_q;
  assign rsp1_rdata = rdata1_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed, table-driven and random checks of sram_port_arbiter against a
// cycle-scheduled response model and a behavioural SRAM macro.
module tb_sram_port_arbiter;
  logic        clk = 0, rst;
  logic        v0 = 0, v1 = 0, we0 = 0, we1 = 0;
  logic [4:0]  a0 = 0, a1 = 0, addr;
  logic [31:0] d0 = 0, d1 = 0, din, rd0, rd1, dout;
  logic        r0, r1, rv0, rv1, csb_n, we_n;
  int          n_chk = 0, n_err = 0, cyc = 0;

  sram_port_arbiter dut (
    .clk(clk), .reset(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
    .req1_valid(v1), .req1_ready(r1), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
    .rsp0_valid(rv0), .rsp0_rdata(rd0), .rsp1_valid(rv1), .rsp1_rdata(rd1),
    .csb_n(csb_n), .we_n(we_n), .addr(addr), .din(din), .dout(dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural macro: one-cycle registered read.
  logic [31:0] sram [32];
  always @(posedge clk) if (csb_n === 1'b0) begin
    if (we_n === 1'b0) sram[addr] <= din;
    else dout <= sram[addr];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Reference model: ordered queue of responses scheduled RD_LAT+2 cycles after acceptance.
  typedef struct {int due; logic own; logic rd; logic [31:0] data;} rsp_t;
  rsp_t        exp_q[$];
  logic [31:0] ref_mem [32];
  logic [31:0] m_rd0, m_rd1, e_din;
  logic [4:0]  e_addr;
  logic        m_last, e_csb, e_we;

  always @(negedge clk) begin
    rsp_t e, n;
    logic ev0, ev1, g, acc, w;
    ev0 = 0;
    ev1 = 0;
    if (rst) begin
      m_last = 1;
      exp_q.delete();
      m_rd0 = 0;
      m_rd1 = 0;
      e_csb = 1;
      e_we = 1;
      e_addr = 0;
      e_din = 0;
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      if (e.own) begin
        ev1 = 1;
        if (e.rd) m_rd1 = e.data;
      end else begin
        ev0 = 1;
        if (e.rd) m_rd0 = e.data;
      end
    end
    if (v0 && v1) g = !m_last;
    else g = !v0;
    acc = !rst && (v0 || v1);
    chk("sb_ready0", r0, acc && !g);
    chk("sb_ready1", r1, acc && g);
    chk("sb_rsp0_valid", rv0, ev0);
    chk("sb_rsp1_valid", rv1, ev1);
    chk("sb_rsp0_rdata", rd0, m_rd0);
    chk("sb_rsp1_rdata", rd1, m_rd1);
    chk("sb_csb_n", csb_n, e_csb);
    chk("sb_we_n", we_n, e_we);
    chk("sb_addr", addr, e_addr);
    chk("sb_din", din, e_din);
    if (acc) begin
      m_last = g;
      w = g ? we1 : we0;
      e_addr = g ? a1 : a0;
      e_din = g ? d1 : d0;
      if (w) ref_mem[e_addr] = e_din;
      n.due = cyc + 3;
      n.own = g;
      n.rd = !w;
      n.data = ref_mem[e_addr];
      exp_q.push_back(n);
      e_csb = 0;
      e_we = !w;
    end else begin
      e_csb = 1;
      e_we = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    v0 = 0;
    v1 = 0;
    we0 = 0;
    we1 = 0;
  endtask
  task automatic drain();
    idle();
    repeat (5) tick();
  endtask

  typedef struct {logic v0, v1, r0, r1;} vec_t;
  vec_t tbl[8];

  initial begin
    for (int i = 0; i < 32; i++) begin
      sram[i] = 0;
      ref_mem[i] = 0;
    end
    dout = 0;
    rst = 1;
    tbl[0] = '{1, 1, 1, 0};
    tbl[1] = '{1, 1, 0, 1};
    tbl[2] = '{1, 0, 1, 0};
    tbl[3] = '{1, 1, 0, 1};
    tbl[4] = '{0, 1, 0, 1};
    tbl[5] = '{1, 1, 1, 0};
    tbl[6] = '{0, 0, 0, 0};
    tbl[7] = '{1, 1, 0, 1};
    repeat (2) tick();
    chk("reset_csb_n", csb_n, 1);
    chk("reset_we_n", we_n, 1);
    chk("reset_addr", addr, 0);
    chk("reset_rsp_valid", {rv0, rv1}, 0);
    rst = 0;
    // Contention straight out of reset: alternating grants, req0 first.
    v0 = 1;
    v1 = 1;
    a0 = 3;
    a1 = 4;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) chk("contend_csb_n", csb_n, 0);
      if (i < 6) begin
        #2;
        chk("contend_ready0", r0, (i % 2) == 0);
        chk("contend_ready1", r1, (i % 2) == 1);
      end else idle();
      tick();
    end
    drain();
    // Arbitration table (pointer favours req0 again after the even contention run).
    foreach (tbl[i]) begin
      v0 = tbl[i].v0;
      v1 = tbl[i].v1;
      a0 = 5'(i);
      a1 = 5'(i + 8);
      #2;
      chk("tbl_ready0", r0, tbl[i].r0);
      chk("tbl_ready1", r1, tbl[i].r1);
      tick();
    end
    drain();
    // Write/read round trip across requesters.
    v0 = 1;
    we0 = 1;
    a0 = 5'h1F;
    d0 = 32'hDEADBEEF;
    tick();
    chk("rt_csb_n", csb_n, 0);
    chk("rt_we_n", we_n, 0);
    chk("rt_addr", addr, 5'h1F);
    chk("rt_din", din, 32'hDEADBEEF);
    idle();
    v1 = 1;
    a1 = 5'h1F;
    tick();
    chk("rt_rd_we_n", we_n, 1);
    idle();
    tick();
    chk("rt_rsp0_valid", rv0, 1);
    chk("rt_rsp1_early", rv1, 0);
    tick();
    chk("rt_rsp1_valid", rv1, 1);
    chk("rt_rsp1_rdata", rd1, 32'hDEADBEEF);
    drain();
    // Streaming: preload 0x10..0x13, then four back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      v0 = 1;
      we0 = 1;
      a0 = 5'(i);
      d0 = 32'h10 + i;
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        v0 = 1;
        we0 = 0;
        a0 = 5'(i);
      end else idle();
      tick();
      if (i + 1 >= 3 && i + 1 <= 6) begin
        chk("stream_rsp0_valid", rv0, 1);
        chk("stream_rsp0_rdata", rd0, 32'h10 + i + 1 - 3);
      end else if (i + 1 == 7) chk("stream_rsp0_end", rv0, 0);
    end
    drain();
    // Hazard: write then read of the same address from req1.
    for (int i = 0; i < 5; i++) begin
      if (i < 2) begin
        v1 = 1;
        we1 = (i == 0);
        a1 = 5'd7;
        d1 = 32'hA5A5A5A5;
      end else idle();
      tick();
      if (i + 1 == 3) chk("hazard_wr_ack", rv1, 1);
      if (i + 1 == 4) begin
        chk("hazard_rd_valid", rv1, 1);
        chk("hazard_rd_data", rd1, 32'hA5A5A5A5);
      end
    end
    drain();
    // Asynchronous reset with a command on the pins and a response pulse in progress.
    v0 = 1;
    a0 = 5'd2;
    repeat (3) tick();
    chk("ar_pre_csb_n", csb_n, 0);
    chk("ar_pre_rsp0", rv0, 1);
    v1 = 1;
    #1 rst = 1;
    #1;
    chk("ar_csb_n", csb_n, 1);
    chk("ar_we_n", we_n, 1);
    chk("ar_ready", {r0, r1}, 0);
    chk("ar_rsp_valid", {rv0, rv1}, 0);
    tick();
    rst = 0;
    idle();
    drain();
    // Mid-flight reset: the pending read is dropped and req0 wins afterwards.
    v0 = 1;
    a0 = 5'd9;
    tick();
    idle();
    #1 rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      chk("mf_no_rsp", {rv0, rv1}, 0);
      tick();
    end
    v0 = 1;
    v1 = 1;
    #2;
    chk("mf_ready0", r0, 1);
    chk("mf_ready1", r1, 0);
    tick();
    drain();
    // Random traffic checked by the reference model.
    for (int i = 0; i < 800; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      a0 = (i % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a1 = (i % 3) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      d0 = $urandom;
      d1 = $urandom;
      tick();
    end
    drain();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
